// File: rtl/mdu_ctrl_if.sv
// Pipeline-to-MDU bundle: E-stage operation/operands and D-stage use flag in,
// handshake status and the architectural HI/LO registers out.
interface mdu_ctrl_if;
    logic [3:0]  md_op_E;
    logic        valid_E;
    logic [31:0] rs_E;
    logic [31:0] rt_E;
    logic        md_use_D;
    logic        start;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output md_op_E, valid_E, rs_E, rt_E, md_use_D,
        input  start, busy, md_stall, hi, lo
    );

    modport slave (
        input  md_op_E, valid_E, rs_E, rt_E, md_use_D,
        output start, busy, md_stall, hi, lo
    );
endinterface

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: computes the result at issue, then holds it in
// ph/pl for a fixed latency before committing it to HI/LO.
//
//   state | meaning
//   IDLE  | accepting MULT/MULTU/DIV/DIVU and MTHI/MTLO
//   RUN   | operation in flight, cnt counts down to commit
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    mdu_ctrl_if.slave  m
);
    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = ($clog2(MAX_CYC + 1) > 4) ? $clog2(MAX_CYC + 1) : 4;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;

    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic [31:0]   hi_q, lo_q, ph, pl;
    logic [31:0]   res_hi, res_lo;
    logic [31:0]   a_mag, b_mag, q_mag, r_mag;
    logic [63:0]   prod;
    logic          is_muldiv, is_mul;

    assign is_muldiv = (m.md_op_E == OP_MULT) || (m.md_op_E == OP_MULTU) ||
                       (m.md_op_E == OP_DIV)  || (m.md_op_E == OP_DIVU);
    assign is_mul    = (m.md_op_E == OP_MULT) || (m.md_op_E == OP_MULTU);

    assign m.start    = ~reset & m.valid_E & is_muldiv & (state == IDLE);
    assign m.busy     = (state == RUN);
    assign m.md_stall = ~reset & m.md_use_D & (m.busy | m.start);
    assign m.hi       = hi_q;
    assign m.lo       = lo_q;

    // Signed divide works on magnitudes so 0x80000000 / -1 needs no special case.
    always_comb begin
        a_mag  = m.rs_E;
        b_mag  = m.rt_E;
        q_mag  = '0;
        r_mag  = '0;
        prod   = '0;
        res_hi = hi_q;
        res_lo = lo_q;
        if (m.md_op_E == OP_DIV) begin
            a_mag = m.rs_E[31] ? -m.rs_E : m.rs_E;
            b_mag = m.rt_E[31] ? -m.rt_E : m.rt_E;
        end
        if (b_mag != 32'd0) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
        case (m.md_op_E)
            OP_MULT: begin
                prod = {{32{m.rs_E[31]}}, m.rs_E} * {{32{m.rt_E[31]}}, m.rt_E};
                {res_hi, res_lo} = prod;
            end
            OP_MULTU: begin
                prod = {32'd0, m.rs_E} * {32'd0, m.rt_E};
                {res_hi, res_lo} = prod;
            end
            OP_DIV: begin
                if (m.rt_E != 32'd0) begin
                    res_lo = (m.rs_E[31] ^ m.rt_E[31]) ? -q_mag : q_mag;
                    res_hi = m.rs_E[31] ? -r_mag : r_mag;
                end
            end
            OP_DIVU: begin
                if (m.rt_E != 32'd0) begin
                    res_lo = q_mag;
                    res_hi = r_mag;
                end
            end
            default: ;
        endcase
    end

    // A zero divisor parks the current HI/LO in ph/pl, so the commit leaves them as-is.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            ph    <= '0;
            pl    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (m.start) begin
                        ph    <= res_hi;
                        pl    <= res_lo;
                        cnt   <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                        state <= RUN;
                    end else if (m.valid_E && m.md_op_E == OP_MTHI) begin
                        hi_q <= m.rs_E;
                    end else if (m.valid_E && m.md_op_E == OP_MTLO) begin
                        lo_q <= m.rs_E;
                    end
                end
                RUN: begin
                    if (cnt <= CW'(1)) begin
                        hi_q  <= ph;
                        lo_q  <= pl;
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
